// File: rtl/md_enc_pkg.sv
// Shared definitions for the Mega Drive pad encoder: button bit positions,
// read-phase constants, the DB9 pin bundle and the idle-timeout length.
package md_enc_pkg;

  localparam int BTN_UP = 0;
  localparam int BTN_DW = 1;
  localparam int BTN_LF = 2;
  localparam int BTN_RG = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_ST = 7;
  localparam int BTN_X  = 8;
  localparam int BTN_Y  = 9;
  localparam int BTN_Z  = 10;
  localparam int BTN_MD = 11;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_ZERO = 3'd3;
  localparam logic [2:0] PH_EXT  = 3'd4;
  localparam logic [2:0] PH_ONES = 3'd5;

  typedef struct packed {
    logic p1;
    logic p2;
    logic p3;
    logic p4;
    logic p6;
    logic p9;
  } md_pins_t;

  function automatic int md_timeout_cycles(input int clk_freq, input int timeout_us);
    return clk_freq / 1000000 * timeout_us;
  endfunction

endpackage

// File: rtl/md_enc_channel.sv
// One pad port: p7 synchroniser, select-edge phase counter with idle timeout,
// and registered pin mapping. MD_ENC_SNAPSHOT_EN adds a per-frame button snapshot.
module md_enc_channel
  import md_enc_pkg::*;
#(
  parameter int CLK_FREQ    = 20000000,
  parameter int TIMEOUT_US  = 1500,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p7,
  input  logic [11:0] buttons,
  input  logic        six_en,
  output logic [5:0]  pins,
  output logic        six_seen,
  output logic [2:0]  phase
);

  localparam int TC = md_timeout_cycles(CLK_FREQ, TIMEOUT_US);
  localparam int CW = $clog2(TC + 1);
  localparam logic [CW-1:0] TC_V = CW'(TC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sel;
  logic                   sel_d;
  logic                   sel_edge;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;
  logic                   expire;
  logic [2:0]             phase_base;
  logic [2:0]             phase_next;
  logic [11:0]            src;
  md_pins_t               map;

  assign sel      = sync_q[SYNC_STAGES-1];
  assign sel_edge = sel ^ sel_d;

`ifdef MD_ENC_SNAPSHOT_EN
  logic [11:0] snap;
  logic        snap_load;

  // The frame-opening edge uses live buttons so its own pins already match the new snapshot.
  assign snap_load = sel_edge && (phase_base == PH_IDLE);
  assign src       = snap_load ? buttons : snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= buttons;
    end else if (snap_load) begin
      snap <= buttons;
    end
  end
`else
  assign src = buttons;
`endif

  // Expiry is folded in before the edge so a coincident edge starts a fresh frame at phase 1.
  always_comb begin
    expire     = (cnt == CW'(1));
    phase_base = expire ? PH_IDLE : phase;
    phase_next = phase_base;
    cnt_next   = cnt;
    if (sel_edge) begin
      phase_next = phase_base + 3'd1;
      cnt_next   = TC_V;
    end else if (cnt != '0) begin
      cnt_next = cnt - CW'(1);
    end
  end

  always_comb begin
    map = '1;
    if (sel) begin
      if (six_en && (phase_next == PH_EXT)) begin
        map = {src[BTN_Z], src[BTN_Y], src[BTN_X], src[BTN_MD], 1'b1, 1'b1};
      end else begin
        map = {src[BTN_UP], src[BTN_DW], src[BTN_LF], src[BTN_RG], src[BTN_B], src[BTN_C]};
      end
    end else if (six_en && (phase_next == PH_ZERO)) begin
      map = {4'b0000, src[BTN_A], src[BTN_ST]};
    end else if (six_en && (phase_next == PH_ONES)) begin
      map = {4'b1111, src[BTN_A], src[BTN_ST]};
    end else begin
      map = {src[BTN_UP], src[BTN_DW], 2'b00, src[BTN_A], src[BTN_ST]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      sel_d    <= 1'b1;
      phase    <= PH_IDLE;
      cnt      <= TC_V;
      pins     <= '1;
      six_seen <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], p7};
      sel_d    <= sel;
      phase    <= phase_next;
      cnt      <= cnt_next;
      pins     <= map;
      six_seen <= six_en && sel_edge && (phase_next == PH_EXT);
    end
  end

endmodule

// File: rtl/md_multi_encoder.sv
// Multi-port Mega Drive pad encoder: one md_enc_channel per DB9 port.
// Define MD_ENC_SNAPSHOT_EN for frame-coherent button snapshots.
module md_multi_encoder
  import md_enc_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CLK_FREQ    = 20000000,
  parameter int TIMEOUT_US  = 1500,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     p7,
  input  logic [12*CHANNELS-1:0]  buttons,
  input  logic [CHANNELS-1:0]     six_en,
  output logic [CHANNELS-1:0]     p1,
  output logic [CHANNELS-1:0]     p2,
  output logic [CHANNELS-1:0]     p3,
  output logic [CHANNELS-1:0]     p4,
  output logic [CHANNELS-1:0]     p6,
  output logic [CHANNELS-1:0]     p9,
  output logic [CHANNELS-1:0]     six_seen,
  output logic [3*CHANNELS-1:0]   dbg_phase
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    md_pins_t pins;

    md_enc_channel #(
      .CLK_FREQ    (CLK_FREQ),
      .TIMEOUT_US  (TIMEOUT_US),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .p7       (p7[i]),
      .buttons  (buttons[12*i +: 12]),
      .six_en   (six_en[i]),
      .pins     (pins),
      .six_seen (six_seen[i]),
      .phase    (dbg_phase[3*i +: 3])
    );

    assign p1[i] = pins.p1;
    assign p2[i] = pins.p2;
    assign p3[i] = pins.p3;
    assign p4[i] = pins.p4;
    assign p6[i] = pins.p6;
    assign p9[i] = pins.p9;
  end

endmodule

// File: tb/tb_md_multi_encoder.sv
// Bench for md_multi_encoder: select bursts, timeout, coincident expiry, reset mid-burst.
module tb_md_multi_encoder;

  localparam int T = 30000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  p7;
  logic [23:0] buttons;
  logic [1:0]  six_en;
  logic [1:0]  p1, p2, p3, p4, p6, p9;
  logic [1:0]  six_seen;
  logic [5:0]  dbg_phase;

  logic [6:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mph[2];
  logic        sel_m[2];
  int          ss_cnt[2] = '{0, 0};
  int          base0, base1;

  always #25 clk = ~clk;

  md_multi_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .p7        (p7),
    .buttons   (buttons),
    .six_en    (six_en),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .p6        (p6),
    .p9        (p9),
    .six_seen  (six_seen),
    .dbg_phase (dbg_phase)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (six_seen[i] === 1'b1) ss_cnt[i]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pins_of(input int ch);
    return {p1[ch], p2[ch], p3[ch], p4[ch], p6[ch], p9[ch]};
  endfunction

  // Reference mapping: b = {md,z,y,x,st,c,b,a,rg,lf,dw,up}
  function automatic logic [5:0] exp_pins(input logic s, input int ph, input logic six,
                                          input logic [11:0] b);
    if (s) begin
      if (six && ph == 4) return {b[10], b[9], b[8], b[11], 1'b1, 1'b1};
      return {b[0], b[1], b[2], b[3], b[5], b[6]};
    end
    if (six && ph == 3) return {4'b0000, b[4], b[7]};
    if (six && ph == 5) return {4'b1111, b[4], b[7]};
    return {b[0], b[1], 2'b00, b[4], b[7]};
  endfunction

  function automatic logic [5:0] model_pins(input int ch);
    return exp_pins(sel_m[ch], mph[ch], six_en[ch], buttons[12*ch +: 12]);
  endfunction

  task automatic p7_edge(input int ch, input bit expire_first);
    logic [5:0] prev;
    logic [6:0] e;
    prev = model_pins(ch);
    p7[ch] = ~p7[ch];
    sel_m[ch] = p7[ch];
    if (expire_first) mph[ch] = 0;
    mph[ch] = (mph[ch] + 1) % 8;
    exp_q.push_back({six_en[ch] && (mph[ch] == 4), model_pins(ch)});
    tick(2);
    check("pins_hold", 32'(pins_of(ch)), 32'(prev));
    tick(1);
    e = exp_q.pop_front();
    check("pins", 32'(pins_of(ch)), 32'(e[5:0]));
    check("six_seen", 32'(six_seen[ch]), 32'(e[6]));
    check("phase", 32'(dbg_phase[3*ch +: 3]), 32'(mph[ch]));
  endtask

  task automatic do_reset();
    p7  = 2'b11;
    rst = 1'b1;
    tick(2);
    for (int ch = 0; ch < 2; ch++) check("rst_pins", 32'(pins_of(ch)), 32'h3f);
    check("rst_six_seen", 32'(six_seen), 32'h0);
    check("rst_phase", 32'(dbg_phase), 32'h0);
    rst = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      mph[ch]   = 0;
      sel_m[ch] = 1'b1;
      check("rel_pins", 32'(pins_of(ch)), 32'h3f);
    end
    tick(1);
    for (int ch = 0; ch < 2; ch++) check("post_rst_pins", 32'(pins_of(ch)), 32'(model_pins(ch)));
    tick(2);
  endtask

  initial begin
    rst     = 1'b1;
    p7      = 2'b11;
    buttons = '1;
    six_en  = 2'b00;
    do_reset();
    check("idle_pins_all_ones", 32'(pins_of(0)), 32'h3f);

    // 6-button burst on channel 0 with x and z pressed
    six_en        = 2'b11;
    buttons[11:0] = 12'hAFF;
    do_reset();
    base0 = ss_cnt[0];
    for (int i = 0; i < 8; i++) begin
      p7_edge(0, 1'b0);
      tick(17);
    end
    check("six_seen_count_6btn", 32'(ss_cnt[0] - base0), 32'd1);

    // Same burst with the 6-button protocol disabled
    six_en = 2'b10;
    do_reset();
    base0 = ss_cnt[0];
    for (int i = 0; i < 8; i++) begin
      p7_edge(0, 1'b0);
      tick(17);
    end
    check("six_seen_count_3btn", 32'(ss_cnt[0] - base0), 32'd0);

`ifndef MD_ENC_SNAPSHOT_EN
    buttons[11:0] = 12'hFFE;
    tick(1);
    check("btn_latency", 32'(pins_of(0)), 32'(model_pins(0)));
`endif

    // Idle timeout after three edges, then an edge coinciding with expiry
    six_en        = 2'b11;
    buttons[11:0] = 12'hAFF;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      p7_edge(0, 1'b0);
      if (i < 2) tick(17);
    end
    tick(T - 1);
    check("timeout_before", 32'(dbg_phase[2:0]), 32'd3);
    tick(1);
    mph[0] = 0;
    check("timeout_phase", 32'(dbg_phase[2:0]), 32'd0);
    check("timeout_pins", 32'(pins_of(0)), 32'(model_pins(0)));
    p7_edge(0, 1'b0);
    tick(T - 3);
    p7_edge(0, 1'b1);
    tick(5);
    check("coincident_hold", 32'(dbg_phase[2:0]), 32'd1);
    p7_edge(0, 1'b0);

    // Channel 1 bursts while channel 0 idles; reset lands on phase 4
    six_en         = 2'b11;
    buttons[11:0]  = 12'hFFF;
    buttons[23:12] = 12'hAFE;
    do_reset();
    base0 = ss_cnt[0];
    base1 = ss_cnt[1];
    for (int i = 0; i < 4; i++) begin
      p7_edge(1, 1'b0);
      check("ch0_idle_pins", 32'(pins_of(0)), 32'(model_pins(0)));
      check("ch0_idle_phase", 32'(dbg_phase[2:0]), 32'd0);
      if (i < 3) tick(17);
    end
    rst = 1'b1;
    tick(1);
    for (int ch = 0; ch < 2; ch++) check("midrst_pins", 32'(pins_of(ch)), 32'h3f);
    check("midrst_phase", 32'(dbg_phase), 32'h0);
    check("midrst_six_seen", 32'(six_seen), 32'h0);
    rst = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      mph[ch]   = 0;
      sel_m[ch] = 1'b1;
    end
    tick(1);
    check("after_rst_ch1", 32'(pins_of(1)), 32'(model_pins(1)));
    check("after_rst_ch0", 32'(pins_of(0)), 32'(model_pins(0)));
    check("six_seen_count_ch1", 32'(ss_cnt[1] - base1), 32'd1);
    check("six_seen_count_ch0", 32'(ss_cnt[0] - base0), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
